// File: rtl/rr_arb_16.sv
// 16-requester round-robin arbiter driving the select of a 16-to-1 mux, with a valid/ready output handshake.
// Optional grant locking is enabled by defining ARB_LOCK_EN.
module rr_arb_16 #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] lock,
  input  logic        out_ready,
  output logic [3:0]  sel,
  output logic [15:0] grant,
  output logic        out_valid,
  output logic [15:0] xfer_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  // N is the downstream mux data width; nothing in this block depends on it.
  localparam int unused_n = N;

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n, sel_n, win;
  logic [15:0] grant_n, cnt_n;
  logic        valid_n, hold;

`ifndef ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // First set bit searched from p+1 upward with wrap; p itself is checked last.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] p);
    logic [3:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int unsigned i = 1; i <= 16; i++) begin
      idx = p + 4'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    grant_n = grant;
    valid_n = out_valid;
    cnt_n   = xfer_cnt;
    hold    = 1'b0;
    win     = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          win     = rr_pick(req, ptr);
          state_n = GRANT;
          sel_n   = win;
          grant_n = 16'b1 << win;
          valid_n = 1'b1;
        end
      end
      GRANT: begin
        if (out_ready) begin
          cnt_n = xfer_cnt + 16'd1;
`ifdef ARB_LOCK_EN
          hold = lock[sel] & req[sel];
`endif
          // A locked transfer keeps both the pointer and the current winner.
          ptr_n = hold ? ptr : sel;
          win   = hold ? sel : rr_pick(req, sel);
          if (|req) begin
            sel_n   = win;
            grant_n = 16'b1 << win;
          end else begin
            state_n = IDLE;
            sel_n   = '0;
            grant_n = '0;
            valid_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '1;
      sel       <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      grant     <= grant_n;
      out_valid <= valid_n;
      xfer_cnt  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_rr_arb_16.sv
// Directed-vector bench for rr_arb_16; inputs change and outputs are sampled on the falling edge.
module tb_rr_arb_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req, lock;
  logic        out_ready;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        out_valid;
  logic [15:0] xfer_cnt;

  int vectors = 0;
  int miscompares = 0;

  rr_arb_16 #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .out_ready(out_ready),
    .sel(sel), .grant(grant), .out_valid(out_valid), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] es, input logic [15:0] eg,
                         input logic ev, input logic [15:0] ec);
    chk({tag, ".sel"}, {28'd0, sel}, {28'd0, es});
    chk({tag, ".grant"}, {16'd0, grant}, {16'd0, eg});
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, ".cnt"}, {16'd0, xfer_cnt}, {16'd0, ec});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; lock = '0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_lock_seq [5];

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; out_ready = 1'b0;
    #3;
    chk_out("reset", 4'd0, 16'h0000, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests stays quiet
    @(negedge clk);
    chk_out("idle", 4'd0, 16'h0000, 1'b0, 16'd0);

    // Single requester 0, back-to-back transfers
    req = 16'h0001; out_ready = 1'b1;
    @(negedge clk);
    chk_out("r0_first", 4'd0, 16'h0001, 1'b1, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk_out("r0_again", 4'd0, 16'h0001, 1'b1, 16'(k));
    end
    req = '0;
    @(negedge clk);
    chk_out("r0_to_idle", 4'd0, 16'h0000, 1'b0, 16'd5);

    // All requesters: full rotation and wrap
    do_reset();
    req = 16'hFFFF; out_ready = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk("rot.sel", {28'd0, sel}, 32'(k % 16));
      chk("rot.cnt", {16'd0, xfer_cnt}, 32'(k));
    end
    @(negedge clk);
    chk("rot.cnt17", {16'd0, xfer_cnt}, 32'd17);

    // 16'h8002 with backpressure: hold, then alternate 15/1
    do_reset();
    req = 16'h8002; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_out("bp_hold", 4'd1, 16'h0002, 1'b1, 16'd0);
      if (k == 2) req = 16'h0000;
      if (k == 3) req = 16'h8002;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_out("bp_next15", 4'd15, 16'h8000, 1'b1, 16'd1);
    @(negedge clk);
    chk_out("bp_next1", 4'd1, 16'h0002, 1'b1, 16'd2);

    // Async reset mid-grant to requester 3
    do_reset();
    req = 16'h0008; out_ready = 1'b1;
    @(negedge clk);
    chk_out("r3_grant", 4'd3, 16'h0008, 1'b1, 16'd0);
    @(negedge clk);
    @(negedge clk);
    chk_out("r3_cnt", 4'd3, 16'h0008, 1'b1, 16'd2);
    #1 rst_n = 1'b0;
    #1 chk_out("r3_async_rst", 4'd0, 16'h0000, 1'b0, 16'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_out("r3_after_rst", 4'd3, 16'h0008, 1'b1, 16'd0);

    // Lock behaviour with req 16'h0011, lock on requester 0 for three transfers
`ifdef ARB_LOCK_EN
    exp_lock_seq = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd4};
`else
    exp_lock_seq = '{4'd0, 4'd4, 4'd0, 4'd4, 4'd0};
`endif
    do_reset();
    req = 16'h0011; lock = 16'h0001; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lock.sel", {28'd0, sel}, {28'd0, exp_lock_seq[k]});
      chk("lock.cnt", {16'd0, xfer_cnt}, 32'(k));
      if (k == 3) lock = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
